// File: rtl/gps_spi_rx.sv
// gps_spi_rx: oversampled SPI receiver for the GPS sample link.
// Recovers 4-bit sample frames, packs two samples per byte and queues the
// bytes in a small FIFO with a valid/ready consumer interface.
module gps_spi_rx #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       MCU_CLK_25_000,
  input  logic       RESET,
  input  logic       MCU_SCK,
  input  logic       MCU_SS,
  input  logic       MCU_MOSI,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  input  logic       RX_READY,
  output logic       OVERRUN,
  output logic       FRAME_ERR,
  input  logic       CLR_ERR
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_ABORT  = 2'd2
  } state_t;

  // synchronizer and edge-detect registers
  logic sck_meta, sck_sync, sck_prev;
  logic ss_meta, ss_sync, ss_prev;
  logic mosi_meta, mosi_sync;

  // guards against joining a frame that was already running at reset release
  logic [1:0] settle;
  logic       armed;

  // receive state
  state_t     state;
  logic [2:0] bit_cnt;
  logic [6:0] shift_reg;
  logic       push_req;
  logic [7:0] push_byte;

  // FIFO state
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  logic          sck_rise, ss_fall, ss_rise;
  logic [2:0]    cnt_upd;
  logic          frame_err_set;
  logic [AW-1:0] wr_idx, rd_idx_n;
  logic          full, do_pop, do_push, overrun_set;
  logic [PW-1:0] wr_ptr_n, rd_ptr_n;

  // two-flop synchronizers plus one history stage for edge detection
  always_ff @(posedge MCU_CLK_25_000) begin
    if (RESET) begin
      sck_meta  <= 1'b0;
      sck_sync  <= 1'b0;
      sck_prev  <= 1'b0;
      ss_meta   <= 1'b1;
      ss_sync   <= 1'b1;
      ss_prev   <= 1'b1;
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
    end else begin
      sck_meta  <= MCU_SCK;
      sck_sync  <= sck_meta;
      sck_prev  <= sck_sync;
      ss_meta   <= MCU_SS;
      ss_sync   <= ss_meta;
      ss_prev   <= ss_sync;
      mosi_meta <= MCU_MOSI;
      mosi_sync <= mosi_meta;
    end
  end

  // arm frame start only once SS has been seen high with a flushed synchronizer
  always_ff @(posedge MCU_CLK_25_000) begin
    if (RESET) begin
      settle <= 2'd0;
      armed  <= 1'b0;
    end else begin
      if (settle != 2'd2) settle <= settle + 2'd1;
      if ((settle == 2'd2) && ss_sync) armed <= 1'b1;
    end
  end

  // edge strobes and the bit count as it will be after this cycle's shift
  always_comb begin
    sck_rise      = sck_sync & ~sck_prev;
    ss_fall       = ~ss_sync & ss_prev;
    ss_rise       = ss_sync & ~ss_prev;
    cnt_upd       = bit_cnt + 3'(sck_rise);
    frame_err_set = (state == ST_ABORT);
  end

  // receive FSM: shift bits in, hand completed bytes to the FIFO
  always_ff @(posedge MCU_CLK_25_000) begin
    if (RESET) begin
      state     <= ST_IDLE;
      bit_cnt   <= 3'd0;
      shift_reg <= 7'd0;
      push_req  <= 1'b0;
      push_byte <= 8'd0;
    end else begin
      push_req <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ss_fall && armed) state <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (sck_rise) begin
            shift_reg <= {shift_reg[5:0], mosi_sync};
            bit_cnt   <= cnt_upd;
            if (bit_cnt == 3'd7) begin
              push_req  <= 1'b1;
              push_byte <= {shift_reg, mosi_sync};
            end
          end
          if (ss_rise) begin
            state <= ((cnt_upd == 3'd0) || (cnt_upd == 3'd4)) ? ST_IDLE : ST_ABORT;
          end
        end
        ST_ABORT: begin
          shift_reg <= 7'd0;
          bit_cnt   <= 3'd0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // FIFO control: a pop in the same cycle frees the slot for a push when full
  always_comb begin
    wr_idx      = wr_ptr[AW-1:0];
    full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    do_pop      = RX_VALID & RX_READY;
    do_push     = push_req & (~full | do_pop);
    overrun_set = push_req & full & ~do_pop;
    wr_ptr_n    = wr_ptr + PW'(do_push);
    rd_ptr_n    = rd_ptr + PW'(do_pop);
    rd_idx_n    = rd_ptr_n[AW-1:0];
  end

  // FIFO storage with registered head byte and valid flag
  always_ff @(posedge MCU_CLK_25_000) begin
    if (RESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      RX_VALID <= 1'b0;
      RX_DATA  <= 8'd0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= 8'd0;
    end else begin
      if (do_push) mem[wr_idx] <= push_byte;
      wr_ptr   <= wr_ptr_n;
      rd_ptr   <= rd_ptr_n;
      RX_VALID <= (wr_ptr_n != rd_ptr_n);
      RX_DATA  <= (do_push && (wr_idx == rd_idx_n)) ? push_byte : mem[rd_idx_n];
    end
  end

  // sticky error flags; a new error event overrides a simultaneous clear
  always_ff @(posedge MCU_CLK_25_000) begin
    if (RESET) begin
      OVERRUN   <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      if (CLR_ERR) begin
        OVERRUN   <= 1'b0;
        FRAME_ERR <= 1'b0;
      end
      if (overrun_set)   OVERRUN   <= 1'b1;
      if (frame_err_set) FRAME_ERR <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gps_spi_rx.sv
// Directed bench for gps_spi_rx: framing, latency, FIFO limits and reset.
module tb_gps_spi_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       sck, ss, mosi;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic       overrun, frame_err, clr_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gps_spi_rx #(.FIFO_DEPTH(4)) dut (
    .MCU_CLK_25_000(clk),
    .RESET         (rst),
    .MCU_SCK       (sck),
    .MCU_SS        (ss),
    .MCU_MOSI      (mosi),
    .RX_DATA       (rx_data),
    .RX_VALID      (rx_valid),
    .RX_READY      (rx_ready),
    .OVERRUN       (overrun),
    .FRAME_ERR     (frame_err),
    .CLR_ERR       (clr_err)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // one SCK period of 4 clocks, MOSI set up 2 clocks before the rise
  task automatic send_bit(input logic b);
    mosi = b;
    sck  = 1'b0;
    tick(2);
    sck  = 1'b1;
    tick(2);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic ss_low();
    ss = 1'b0;
    tick(3);
  endtask

  task automatic ss_high();
    ss = 1'b1;
    tick(5);
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    chk1({tag, "_valid"}, rx_valid, 1'b1);
    chk8({tag, "_data"}, rx_data, exp);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] v;
    rst = 1'b1; sck = 1'b0; ss = 1'b1; mosi = 1'b0;
    rx_ready = 1'b0; clr_err = 1'b0;
    tick(3);
    chk1("rst_valid", rx_valid, 1'b0);
    chk8("rst_data", rx_data, 8'h00);
    chk1("rst_overrun", overrun, 1'b0);
    chk1("rst_frame_err", frame_err, 1'b0);
    rst = 1'b0;
    tick(4);

    // two nibbles under one SS, latency of the 8th bit, immediate pop
    rx_ready = 1'b1;
    ss_low();
    send_bit(1); send_bit(0); send_bit(1); send_bit(1);
    send_bit(0); send_bit(1); send_bit(1);
    mosi = 1'b0;
    sck  = 1'b0;
    tick(2);
    sck  = 1'b1;
    tick(3);
    chk1("lat_edge2_valid", rx_valid, 1'b0);
    tick(1);
    chk1("lat_edge3_valid", rx_valid, 1'b1);
    chk8("lat_edge3_data", rx_data, 8'hB6);
    tick(1);
    chk1("pop_valid_low", rx_valid, 1'b0);
    ss_high();
    chk1("b6_frame_err", frame_err, 1'b0);
    rx_ready = 1'b0;

    // half byte retained across SS deassert
    ss_low();
    send_bit(1); send_bit(1); send_bit(1); send_bit(1);
    ss_high();
    ss_low();
    send_bit(0); send_bit(0); send_bit(0); send_bit(1);
    ss_high();
    pop_check("f1", 8'hF1);
    chk1("f1_frame_err", frame_err, 1'b0);
    chk1("f1_empty", rx_valid, 1'b0);

    // 6-bit frame aborts, next byte clean, clear error
    ss_low();
    send_bit(1); send_bit(1); send_bit(0); send_bit(0); send_bit(1); send_bit(1);
    ss_high();
    chk1("abort_frame_err", frame_err, 1'b1);
    chk1("abort_no_push", rx_valid, 1'b0);
    ss_low();
    send_byte(8'h5A);
    ss_high();
    pop_check("5a", 8'h5A);
    chk1("frame_err_sticky", frame_err, 1'b1);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    chk1("frame_err_cleared", frame_err, 1'b0);

    // overrun with 5 bytes into a 4-deep FIFO
    ss_low();
    for (int b = 1; b <= 5; b++) send_byte(8'(b));
    ss_high();
    chk1("overrun_set", overrun, 1'b1);
    pop_check("ov_01", 8'h01);
    pop_check("ov_02", 8'h02);
    pop_check("ov_03", 8'h03);
    pop_check("ov_04", 8'h04);
    chk1("ov_empty", rx_valid, 1'b0);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    chk1("overrun_cleared", overrun, 1'b0);

    // pop coincident with the push into a full FIFO
    ss_low();
    for (int b = 1; b <= 4; b++) send_byte(8'(b));
    v = 8'h05;
    for (int i = 7; i >= 1; i--) send_bit(v[i]);
    mosi = v[0];
    sck  = 1'b0;
    tick(2);
    sck  = 1'b1;
    tick(3);
    chk1("full_before_push", rx_valid, 1'b1);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    ss_high();
    chk1("pushpop_no_overrun", overrun, 1'b0);
    pop_check("pp_02", 8'h02);
    pop_check("pp_03", 8'h03);
    pop_check("pp_04", 8'h04);
    pop_check("pp_05", 8'h05);
    chk1("pp_empty", rx_valid, 1'b0);

    // SS already low at reset release must not start a frame
    ss  = 1'b0;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
    for (int i = 0; i < 8; i++) send_bit(1'b1);
    tick(4);
    chk1("midstream_no_push", rx_valid, 1'b0);
    ss_high();
    ss_low();
    send_byte(8'hC3);
    ss_high();
    pop_check("c3", 8'hC3);
    chk1("c3_frame_err", frame_err, 1'b0);

    // reset part-way through a byte with data in the FIFO
    ss_low();
    send_byte(8'h77);
    send_bit(1); send_bit(0); send_bit(1);
    chk8("pre_rst_data", rx_data, 8'h77);
    rst = 1'b1;
    tick(1);
    chk1("midrst_valid", rx_valid, 1'b0);
    chk8("midrst_data", rx_data, 8'h00);
    chk1("midrst_overrun", overrun, 1'b0);
    chk1("midrst_frame_err", frame_err, 1'b0);
    rst = 1'b0;
    tick(2);
    ss_high();
    chk1("post_rst_frame_err", frame_err, 1'b0);
    chk1("post_rst_empty", rx_valid, 1'b0);
    ss_low();
    send_byte(8'h3C);
    ss_high();
    pop_check("3c", 8'h3C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
